// File: rtl/e203_exu_rf_wbck_ctrl.sv
// Regfile write-port controller: arbitrates ALU and long-pipe writebacks onto one
// registered write port and tracks outstanding long-pipe destinations for dispatch.
module e203_exu_rf_wbck_ctrl #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int RFREG_NUM  = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [XLEN-1:0]    longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
  input  logic               disp_longp_ena,
  input  logic [RFIDX_W-1:0] disp_rdidx,
  input  logic [RFIDX_W-1:0] disp_rs1idx,
  input  logic [RFIDX_W-1:0] disp_rs2idx,
  output logic               dep_rs1,
  output logic               dep_rs2,
  output logic               dep_rd,
  output logic               rf_wbck_o_ena,
  output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
  output logic [XLEN-1:0]    rf_wbck_o_wdat,
  output logic               sb_empty,
  output logic               sb_err
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]     starve_q, starve_d;
  logic                 alu_gnt, longp_gnt, hs;
  logic [RFIDX_W-1:0]   win_idx;
  logic [XLEN-1:0]      win_dat;
  logic                 ena_q, ena_d;
  logic [RFIDX_W-1:0]   idx_q, idx_d;
  logic [XLEN-1:0]      dat_q, dat_d;
  logic                 src_lp_q, src_lp_d;
  logic [RFREG_NUM-1:1] sb_q, sb_d;
  logic [RFREG_NUM-1:0] sb_full;
  logic                 err_q, err_d;
  logic                 set_en, clr_en;

  // Long-pipe wins unless the ALU has lost STARVE_MAX arbitrations in a row.
  assign alu_gnt   = alu_wbck_i_valid & (~longp_wbck_i_valid | (starve_q == STARVE_LIM));
  assign longp_gnt = longp_wbck_i_valid & ~alu_gnt;
  assign hs        = alu_gnt | longp_gnt;
  assign win_idx   = longp_gnt ? longp_wbck_i_rdidx : alu_wbck_i_rdidx;
  assign win_dat   = longp_gnt ? longp_wbck_i_wdat  : alu_wbck_i_wdat;

  assign alu_wbck_i_ready   = alu_gnt;
  assign longp_wbck_i_ready = longp_gnt;

  always_comb begin
    starve_d = starve_q;
    if (!alu_wbck_i_valid || alu_gnt) begin
      starve_d = '0;
    end else if (longp_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_comb begin
    ena_d    = hs & (win_idx != '0);
    idx_d    = ena_d ? win_idx : idx_q;
    dat_d    = ena_d ? win_dat : dat_q;
    src_lp_d = ena_d & longp_gnt;
  end

  // Clear happens when the long-pipe write actually reaches the regfile; set wins over clear.
  assign set_en  = disp_longp_ena & (disp_rdidx != '0);
  assign clr_en  = ena_q & src_lp_q;
  assign sb_full = {sb_q, 1'b0};

  always_comb begin
    sb_d = sb_q;
    for (int i = 1; i < RFREG_NUM; i++) begin
      sb_d[i] = (set_en && (disp_rdidx == RFIDX_W'(i))) |
                (sb_q[i] & ~(clr_en && (idx_q == RFIDX_W'(i))));
    end
    err_d = err_q | (set_en & sb_full[disp_rdidx] & ~(clr_en && (idx_q == disp_rdidx)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      ena_q    <= 1'b0;
      idx_q    <= '0;
      dat_q    <= '0;
      src_lp_q <= 1'b0;
      sb_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      ena_q    <= ena_d;
      idx_q    <= idx_d;
      dat_q    <= dat_d;
      src_lp_q <= src_lp_d;
      sb_q     <= sb_d;
      err_q    <= err_d;
    end
  end

  assign dep_rs1         = sb_full[disp_rs1idx];
  assign dep_rs2         = sb_full[disp_rs2idx];
  assign dep_rd          = sb_full[disp_rdidx];
  assign rf_wbck_o_ena   = ena_q;
  assign rf_wbck_o_rdidx = idx_q;
  assign rf_wbck_o_wdat  = dat_q;
  assign sb_empty        = ~|sb_q;
  assign sb_err          = err_q;

endmodule

// File: tb/tb_e203_exu_rf_wbck_ctrl.sv
// Bench for the regfile writeback controller: directed scenarios plus random traffic,
// checked against a behavioural model with a queue of expected regfile writes.
module tb_e203_exu_rf_wbck_ctrl;
  localparam int STARVE_MAX = 4;

  logic        clk, rst;
  logic        alu_v, alu_rdy, lp_v, lp_rdy;
  logic [31:0] alu_dat, lp_dat, wr_dat;
  logic [4:0]  alu_rd, lp_rd, d_rd, d_rs1, d_rs2, wr_idx;
  logic        d_en, dep1, dep2, depd, wr_ena, sbe, sberr;

  e203_exu_rf_wbck_ctrl #(.XLEN(32), .RFIDX_W(5), .RFREG_NUM(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .alu_wbck_i_valid(alu_v), .alu_wbck_i_ready(alu_rdy),
    .alu_wbck_i_wdat(alu_dat), .alu_wbck_i_rdidx(alu_rd),
    .longp_wbck_i_valid(lp_v), .longp_wbck_i_ready(lp_rdy),
    .longp_wbck_i_wdat(lp_dat), .longp_wbck_i_rdidx(lp_rd),
    .disp_longp_ena(d_en), .disp_rdidx(d_rd), .disp_rs1idx(d_rs1), .disp_rs2idx(d_rs2),
    .dep_rs1(dep1), .dep_rs2(dep2), .dep_rd(depd),
    .rf_wbck_o_ena(wr_ena), .rf_wbck_o_rdidx(wr_idx), .rf_wbck_o_wdat(wr_dat),
    .sb_empty(sbe), .sb_err(sberr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int cyc; logic [4:0] idx; logic [31:0] dat;} wr_t;
  wr_t exp_q[$];
  int  cyc_cnt = 0;
  int  checks = 0, errors = 0;

  // Reference model state
  int  lost;
  bit  pend[32];
  bit  m_err;
  bit  land_lp;
  int  land_idx;
  bit  last_a_g, last_l_g;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc_cnt, act, exp);
    end
  endtask

  function automatic bit pend_none();
    foreach (pend[i]) if (pend[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    lost = 0; m_err = 0; land_lp = 0; land_idx = 0;
    foreach (pend[i]) pend[i] = 0;
    exp_q.delete();
  endtask

  task automatic zero_inputs();
    alu_v = 0; alu_rd = 0; alu_dat = 0; lp_v = 0; lp_rd = 0; lp_dat = 0;
    d_en = 0; d_rd = 0; d_rs1 = 0; d_rs2 = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      bit ev;
      wr_t e;
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc_cnt);
      chk("wr_ena", wr_ena, ev);
      if (ev) begin
        e = exp_q.pop_front();
        chk("wr_idx", wr_idx, e.idx);
        chk("wr_dat", wr_dat, e.dat);
      end
    end
  end

  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     input logic de, input logic [4:0] drd,
                     input logic [4:0] r1, input logic [4:0] r2);
    bit a_g, l_g, clr, set;
    int rd;
    @(negedge clk);
    alu_v = av; alu_rd = ard; alu_dat = adat;
    lp_v = lv; lp_rd = lrd; lp_dat = ldat;
    d_en = de; d_rd = drd; d_rs1 = r1; d_rs2 = r2;
    #1;
    a_g = av && (!lv || lost >= STARVE_MAX);
    l_g = lv && !a_g;
    chk("alu_ready", alu_rdy, a_g);
    chk("lp_ready", lp_rdy, l_g);
    chk("dep_rs1", dep1, (r1 != 0) && pend[r1]);
    chk("dep_rs2", dep2, (r2 != 0) && pend[r2]);
    chk("dep_rd", depd, (drd != 0) && pend[drd]);
    chk("sb_empty", sbe, pend_none());
    chk("sb_err", sberr, m_err);
    if (a_g || l_g) begin
      rd = l_g ? lrd : ard;
      if (rd != 0) exp_q.push_back('{cyc_cnt + 1, 5'(rd), l_g ? ldat : adat});
    end
    if (!av || a_g) lost = 0;
    else if (l_g && lost < STARVE_MAX) lost++;
    clr = land_lp;
    set = de && (drd != 0);
    if (set && pend[drd] && !(clr && land_idx == drd)) m_err = 1;
    if (clr) pend[land_idx] = 0;
    if (set) pend[drd] = 1;
    rd = l_g ? lrd : ard;
    land_lp  = l_g && (rd != 0);
    land_idx = land_lp ? rd : land_idx;
    last_a_g = a_g; last_l_g = l_g;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; zero_inputs();
    #1;
    chk("rst_ena", wr_ena, 0);
    chk("rst_sb_empty", sbe, 1);
    chk("rst_sb_err", sberr, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    logic        ap_v, lpp_v;
    logic [4:0]  ap_rd, lpp_rd;
    logic [31:0] ap_dat, lpp_dat;
    rst = 1; zero_inputs(); model_reset();
    #3;
    chk("init_ena", wr_ena, 0);
    chk("init_idx", wr_idx, 0);
    chk("init_dat", wr_dat, 0);
    chk("init_sb_empty", sbe, 1);
    chk("init_sb_err", sberr, 0);
    chk("init_alu_rdy", alu_rdy, 0);
    @(negedge clk); rst = 0;

    // ALU alone
    cyc(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    idle(); idle();

    // Contention: ALU wins every fifth cycle
    for (int k = 0; k < 15; k++) begin
      cyc(1, 5'd3, 32'hA000 + k, 1, 5'd4, 32'hB000 + k, 0, 0, 0, 0);
      chk("contention_pattern", alu_rdy, (k % 5) == 4);
    end
    idle();

    // x0 long-pipe write
    cyc(0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 0);
    idle(); idle();

    // Scoreboard lifecycle on x7
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    cyc(0, 0, 0, 1, 7, 32'h7777, 0, 0, 7, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("lifecycle_dep_drop", dep1, 0);
    chk("lifecycle_empty", sbe, 1);

    // Same-cycle set/clear on x9, then a true WAW dispatch
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    cyc(0, 0, 0, 1, 9, 32'h9999, 0, 0, 9, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    chk("setclr_keep", dep1, 1);
    chk("setclr_no_err", sberr, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    idle(); idle();
    chk("waw_err_sticky", sberr, 1);

    // Reset mid-write with x7 pending
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    cyc(1, 3, 32'h3333, 0, 0, 0, 0, 0, 7, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_ena", wr_ena, 1);
    chk("pre_rst_dep", dep1, 1);
    rst = 1; zero_inputs();
    #1;
    chk("async_rst_ena", wr_ena, 0);
    chk("async_rst_empty", sbe, 1);
    chk("async_rst_err", sberr, 0);
    chk("async_rst_dep", dep1, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk); rst = 0;

    // Random traffic; requesters hold their request until granted
    ap_v = 0; lpp_v = 0; ap_rd = 0; lpp_rd = 0; ap_dat = 0; lpp_dat = 0;
    for (int n = 0; n < 400; n++) begin
      logic de;
      logic [4:0] drd;
      if (!ap_v && $urandom_range(0, 1) == 1) begin
        ap_v = 1; ap_rd = 5'($urandom_range(0, 31)); ap_dat = $urandom;
      end
      if (!lpp_v && $urandom_range(0, 2) != 0) begin
        lpp_v = 1; lpp_rd = 5'($urandom_range(0, 31)); lpp_dat = $urandom;
      end
      de  = ($urandom_range(0, 3) == 0);
      drd = 5'($urandom_range(0, 31));
      cyc(ap_v, ap_rd, ap_dat, lpp_v, lpp_rd, lpp_dat, de, drd,
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (last_a_g) ap_v = 0;
      if (last_l_g) lpp_v = 0;
    end
    idle(); idle(); idle();
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/e203_exu_rf_wbck_ctrl.md
Name: e203_exu_rf_wbck_ctrl

Overview:
- Write-port controller for the integer register file.
- Arbitrates two writeback requesters (single-cycle ALU, long-pipe) onto the single regfile write port through one registered stage.
- Holds a destination scoreboard of outstanding long-pipe writes and gives dispatch the dependency flags for src1/src2/dest.
- Sits between the EXU commit/writeback logic and the regfile write port.

Parameters:
- XLEN, 32, data width of writeback data.
- RFIDX_W, 5, register index width.
- RFREG_NUM, 32, number of architectural registers; x0 is never tracked or written.
- STARVE_MAX, 4, consecutive lost ALU arbitrations before ALU is forced to win; range 1..15.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- alu_wbck_i_valid  in  1  ALU writeback request
- alu_wbck_i_ready  out  1  ALU request granted this cycle
- alu_wbck_i_wdat  in  XLEN  ALU result
- alu_wbck_i_rdidx  in  RFIDX_W  ALU destination index
- longp_wbck_i_valid  in  1  long-pipe writeback request
- longp_wbck_i_ready  out  1  long-pipe request granted this cycle
- longp_wbck_i_wdat  in  XLEN  long-pipe result
- longp_wbck_i_rdidx  in  RFIDX_W  long-pipe destination index
- disp_longp_ena  in  1  long-pipe instruction dispatched this cycle
- disp_rdidx  in  RFIDX_W  its destination index
- disp_rs1idx  in  RFIDX_W  dispatch-stage source 1 index
- disp_rs2idx  in  RFIDX_W  dispatch-stage source 2 index
- dep_rs1  out  1  rs1 has a pending write
- dep_rs2  out  1  rs2 has a pending write
- dep_rd  out  1  rd has a pending write (WAW)
- rf_wbck_o_ena  out  1  regfile write enable
- rf_wbck_o_rdidx  out  RFIDX_W  regfile write index
- rf_wbck_o_wdat  out  XLEN  regfile write data
- sb_empty  out  1  no pending long-pipe writes
- sb_err  out  1  sticky: dispatch to an already-pending rd

Behaviour:
- Reset values: all outputs 0, except sb_empty=1. Scoreboard vector, starvation counter and output stage all cleared.
- Arbitration is combinational, one grant per cycle, ready = grant.
  - Long-pipe has priority.
  - ALU wins when longp_valid=0, or when both are valid and starve_cnt==STARVE_MAX.
- starve_cnt update:
  - Increments when alu_valid & longp granted.
  - Resets to 0 on ALU grant, or on any cycle with alu_valid=0.
  - Saturates at STARVE_MAX.
- Handshake = valid & ready. Requesters hold valid/data stable until ready; the block does not register requests.
- Output stage, registered, one-cycle latency:
  - On a handshake with rdidx!=0: next cycle rf_wbck_o_ena=1 with the winner's idx/data.
  - rdidx==0: request is accepted (ready=1) but ena stays 0.
  - No handshake: ena=0; idx/data hold their previous values.
- Scoreboard sb[RFREG_NUM-1:1], bit 0 constant 0.
  - Set: disp_longp_ena & disp_rdidx!=0 sets sb[disp_rdidx].
  - Clear: sb[rf_wbck_o_rdidx] clears when rf_wbck_o_ena=1 and the output stage holds a long-pipe write. A src_is_longp flag is registered alongside the stage. The clear therefore lands in the cycle the regfile is actually written, not at the handshake.
  - Set and clear of the same index in the same cycle: set wins, bit stays 1.
  - Dispatch to an index already set (and not clearing this cycle): bit stays 1, sb_err sets and holds until reset.
- Dependency outputs are combinational: dep_rs1=sb[disp_rs1idx], dep_rs2=sb[disp_rs2idx], dep_rd=sb[disp_rdidx]. Index 0 always yields 0.
- sb_empty = ~|sb, registered view (same cycle as sb).
- ALU writes never touch the scoreboard. Upstream is responsible for stalling ALU writes to a pending rd.
- Reset asserted mid-operation: output stage, scoreboard, counter and sb_err clear immediately, asynchronously. The first possible write occurs 1 cycle after reset deasserts plus a handshake.

Test Plan:
- ALU alone: alu_valid=1, rdidx=5, wdat=0x1234 -> ready=1 same cycle; next cycle ena=1, idx=5, dat=0x1234; cycle after, ena=0.
- Contention: both valid continuously, STARVE_MAX=4 -> longp granted 4 cycles, ALU on cycle 5, longp resumes; pattern repeats every 5 cycles.
- x0 write: longp_valid=1, rdidx=0 -> ready=1, ena stays 0, scoreboard unchanged.
- Scoreboard lifecycle:
  - disp_longp_ena with rd=7 -> next cycle sb_empty=0; dep_rs1=1 when disp_rs1idx=7.
  - longp handshake rd=7 at cycle T -> ena=1 at T+1; dep_rs1 drops at T+2; sb_empty=1 at T+2.
- Same-cycle set/clear on rd=9 -> sb[9] remains 1, sb_err=0. A second dispatch to rd=9 while pending -> sb_err=1 sticky.
- Reset mid-write: assert rst while ena=1 and sb=0x80 -> ena=0, sb_empty=1, sb_err=0 immediately, without a clock edge.
